// File: rtl/mandelbrot_renderer.sv
// Fixed-point Mandelbrot renderer: iterates z <- z^2 + c per pixel and writes one byte-lane pixel per de_req/de_ack.
// Define JULIA_MODE_EN to add Julia-set mode (c = r4/r5 for the frame, z starts at the pixel coordinate, r6[0] selects).
module mandelbrot_renderer #(
    parameter int INT_LEN       = 4,
    parameter int FRAC_LEN      = 28,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_W        = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    input  logic [15:0]       r6,
    input  logic [15:0]       r7,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-1:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic [31:0]       de_data
);
    localparam int Q_LEN = INT_LEN + FRAC_LEN;
    localparam int W2    = 2 * Q_LEN;
    localparam int W2P   = W2 + 1;
    localparam int XW    = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW    = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int AW    = ADDR_W + 2;
    localparam logic [W2P-1:0] FOUR = W2P'(1) << (2 * FRAC_LEN + 2);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_WRITE} state_t;
    typedef logic signed [Q_LEN-1:0] fix_t;

    // Signed Q4.12 command value -> internal Q format.
    function automatic fix_t from_q412(input logic [15:0] v);
        fix_t t;
        t = {{(Q_LEN - 16){v[15]}}, v};
        return t <<< (FRAC_LEN - 12);
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       max_q, max_d, iter_q, iter_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    fix_t              start_r_q, start_r_d, step_q, step_d;
    fix_t              p_r_q, p_r_d, p_i_q, p_i_d;
    fix_t              c_r_q, c_r_d, c_i_q, c_i_d, z_r_q, z_r_d, z_i_q, z_i_d;
    logic              ack_q, ack_d, de_req_q, de_req_d;
    logic [ADDR_W-1:0] de_addr_q, de_addr_d;
    logic [3:0]        de_nbyte_q, de_nbyte_d;
    logic [31:0]       de_data_q, de_data_d;

    logic signed [W2-1:0] z_r_w, z_i_w, zr2, zi2, zri;
    logic [W2P-1:0]       mag;
    fix_t                 zr2_t, zi2_t, zri_t, nz_r, nz_i;
    fix_t                 nxt_p_r, nxt_p_i, load_p_r, load_p_i, load_c_r, load_c_i;
    logic                 escape, capped, last_col, last_row, load_px;
    logic [AW-1:0]        pix_addr;
    logic [7:0]           colour;
    logic                 unused_bits;

`ifdef JULIA_MODE_EN
    logic julia_q, julia_d;
    fix_t jc_r_q, jc_r_d, jc_i_q, jc_i_d;
    assign julia_d = (state_q == S_IDLE && req) ? r6[0] : julia_q;
    assign jc_r_d  = (state_q == S_IDLE && req) ? from_q412(r4) : jc_r_q;
    assign jc_i_d  = (state_q == S_IDLE && req) ? from_q412(r5) : jc_i_q;
    assign load_c_r = julia_d ? jc_r_d : load_p_r;
    assign load_c_i = julia_d ? jc_i_d : load_p_i;
    assign unused_bits = ^{r6[15:1], r7, zri};
`else
    assign load_c_r = load_p_r;
    assign load_c_i = load_p_i;
    assign unused_bits = ^{r4, r5, r6, r7, zri};
`endif

    // Squares are kept at full width for the escape test; the update path truncates back to Q_LEN.
    always_comb begin
        z_r_w    = W2'(z_r_q);
        z_i_w    = W2'(z_i_q);
        zr2      = z_r_w * z_r_w;
        zi2      = z_i_w * z_i_w;
        zri      = z_r_w * z_i_w;
        mag      = {1'b0, zr2} + {1'b0, zi2};
        escape   = (mag >= FOUR);
        capped   = (iter_q >= max_q);
        zr2_t    = zr2[FRAC_LEN +: Q_LEN];
        zi2_t    = zi2[FRAC_LEN +: Q_LEN];
        zri_t    = zri[FRAC_LEN +: Q_LEN];
        nz_r     = zr2_t - zi2_t + c_r_q;
        nz_i     = (zri_t <<< 1) + c_i_q;
        colour   = escape ? iter_q[7:0] : 8'h00;
        pix_addr = AW'(y_q) * AW'(SCREEN_WIDTH) + AW'(x_q);
        last_col = (x_q == XW'(SCREEN_WIDTH - 1));
        last_row = (y_q == YW'(SCREEN_HEIGHT - 1));
        nxt_p_r  = last_col ? start_r_q : p_r_q + step_q;
        nxt_p_i  = last_col ? p_i_q + step_q : p_i_q;
        load_p_r = (state_q == S_IDLE) ? from_q412(r1) : nxt_p_r;
        load_p_i = (state_q == S_IDLE) ? from_q412(r2) : nxt_p_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req) state_d = S_ITER;
            S_ITER:  if (escape || capped) state_d = S_WRITE;
            S_WRITE: if (de_ack) state_d = (last_col && last_row) ? S_IDLE : S_ITER;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
        max_d      = max_q;
        iter_d     = iter_q;
        x_d        = x_q;
        y_d        = y_q;
        start_r_d  = start_r_q;
        step_d     = step_q;
        p_r_d      = p_r_q;
        p_i_d      = p_i_q;
        c_r_d      = c_r_q;
        c_i_d      = c_i_q;
        z_r_d      = z_r_q;
        z_i_d      = z_i_q;
        ack_d      = 1'b0;
        de_req_d   = de_req_q;
        de_addr_d  = de_addr_q;
        de_nbyte_d = de_nbyte_q;
        de_data_d  = de_data_q;
        load_px    = 1'b0;
        unique case (state_q)
            S_IDLE: if (req) begin
                max_d     = (r0 == 16'd0) ? 16'd1 : r0;
                start_r_d = load_p_r;
                step_d    = Q_LEN'(r3) << (FRAC_LEN - 16);
                x_d       = '0;
                y_d       = '0;
                p_r_d     = load_p_r;
                p_i_d     = load_p_i;
                load_px   = 1'b1;
                ack_d     = 1'b1;
            end
            S_ITER: if (escape || capped) begin
                de_req_d   = 1'b1;
                de_addr_d  = pix_addr[ADDR_W+1:2];
                de_nbyte_d = ~(4'b0001 << pix_addr[1:0]);
                de_data_d  = {4{colour}};
            end else begin
                z_r_d  = nz_r;
                z_i_d  = nz_i;
                iter_d = iter_q + 16'd1;
            end
            S_WRITE: if (de_ack) begin
                de_req_d = 1'b0;
                if (!(last_col && last_row)) begin
                    x_d     = last_col ? '0 : x_q + XW'(1);
                    y_d     = last_col ? y_q + YW'(1) : y_q;
                    p_r_d   = load_p_r;
                    p_i_d   = load_p_i;
                    load_px = 1'b1;
                end
            end
            default: ;
        endcase
        if (load_px) begin
            z_r_d  = load_p_r;
            z_i_d  = load_p_i;
            c_r_d  = load_c_r;
            c_i_d  = load_c_i;
            iter_d = 16'd1;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            de_req_q   <= 1'b0;
            de_addr_q  <= '0;
            de_nbyte_q <= 4'b1110;
            de_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            de_req_q   <= de_req_d;
            de_addr_q  <= de_addr_d;
            de_nbyte_q <= de_nbyte_d;
            de_data_q  <= de_data_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are all loaded at request accept before being used.
    always_ff @(posedge clk) begin
        max_q     <= max_d;
        iter_q    <= iter_d;
        x_q       <= x_d;
        y_q       <= y_d;
        start_r_q <= start_r_d;
        step_q    <= step_d;
        p_r_q     <= p_r_d;
        p_i_q     <= p_i_d;
        c_r_q     <= c_r_d;
        c_i_q     <= c_i_d;
        z_r_q     <= z_r_d;
        z_i_q     <= z_i_d;
`ifdef JULIA_MODE_EN
        julia_q   <= julia_d;
        jc_r_q    <= jc_r_d;
        jc_i_q    <= jc_i_d;
`endif
    end

    assign ack      = ack_q;
    assign busy     = (state_q != S_IDLE);
    assign de_req   = de_req_q;
    assign de_addr  = de_addr_q;
    assign de_nbyte = de_nbyte_q;
    assign de_data  = de_data_q;
endmodule

// File: tb/tb_mandelbrot_renderer.sv
// Directed bench for mandelbrot_renderer on an 8x4 screen; Julia frame runs only when JULIA_MODE_EN is defined.
module tb_mandelbrot_renderer;
    logic        clk = 1'b0;
    logic        rst, req, ack, busy, de_req, de_ack;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic [31:0] de_data;

    int total = 0;
    int bad   = 0;
    int exp_col [32];
    int exp_max;
    int acks;

    always #5 clk = ~clk;

    mandelbrot_renderer #(
        .SCREEN_WIDTH (8),
        .SCREEN_HEIGHT(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .busy    (busy),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7),
        .de_req  (de_req),
        .de_ack  (de_ack),
        .de_addr (de_addr),
        .de_nbyte(de_nbyte),
        .de_data (de_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_col(input int v);
        for (int i = 0; i < 32; i++) exp_col[i] = v;
    endtask

    task automatic start_frame(input bit hold);
        req = 1'b1;
        @(negedge clk);
        check("accept_ack", 32'(ack), 32'd1);
        check("accept_busy", 32'(busy), 32'd1);
        if (!hold) req = 1'b0;
    endtask

    // Starts at the first ITER cycle of pixel 0; ends at the negedge inside the last WRITE.
    task automatic run_pixels(input int n_pix, input int stall_pix, output int n_acks);
        int          cnt;
        logic [17:0] a;
        logic [31:0] d;
        logic [3:0]  nb, nb_exp;
        logic [7:0]  c;
        n_acks = 0;
        for (int p = 0; p < n_pix; p++) begin
            cnt = 0;
            while (de_req !== 1'b1 && cnt < 200) begin
                if (ack === 1'b1) n_acks++;
                cnt++;
                @(negedge clk);
            end
            check("de_req_seen", 32'(cnt < 200), 32'd1);
            nb_exp = ~(4'b0001 << (p % 4));
            c      = 8'(exp_col[p]);
            check("de_addr", 32'(de_addr), 32'(p >> 2));
            check("de_nbyte", {28'd0, de_nbyte}, {28'd0, nb_exp});
            check("de_data", de_data, {4{c}});
            check("pixel_cycles", 32'(cnt + 1),
                  32'((exp_col[p] == 0) ? exp_max + 1 : exp_col[p] + 1));
            if (p == stall_pix) begin
                de_ack = 1'b0;
                a  = de_addr;
                d  = de_data;
                nb = de_nbyte;
                repeat (10) begin
                    @(negedge clk);
                    check("stall_de_req", 32'(de_req), 32'd1);
                    check("stall_de_addr", 32'(de_addr), 32'(a));
                    check("stall_de_data", de_data, d);
                    check("stall_de_nbyte", {28'd0, de_nbyte}, {28'd0, nb});
                end
                de_ack = 1'b1;
            end
            if (p != n_pix - 1) @(negedge clk);
        end
    endtask

    task automatic end_of_frame();
        check("busy_last_write", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("de_req_after_frame", 32'(de_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; de_ack = 1'b1;
        r0 = 16'd0; r1 = 16'd0; r2 = 16'd0; r3 = 16'd0;
        r4 = 16'd0; r5 = 16'd0; r6 = 16'd0; r7 = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_de_req", 32'(de_req), 32'd0);
        check("rst_de_addr", 32'(de_addr), 32'd0);
        check("rst_de_nbyte", {28'd0, de_nbyte}, 32'hE);
        check("rst_de_data", de_data, 32'd0);

        // Non-escaping frame: origin stays in the set, capped at 16 iterations.
        r0 = 16'd16; exp_max = 16; fill_col(0);
        start_frame(1'b0);
        run_pixels(32, -1, acks);
        end_of_frame();

        // Immediate escape at 3.0 with back-pressure on the 5th write.
        r1 = 16'h3000; fill_col(1);
        start_frame(1'b0);
        run_pixels(32, 4, acks);
        end_of_frame();

        // req held high for a whole frame: one ack, restart only once idle.
        start_frame(1'b1);
        run_pixels(32, -1, acks);
        check("single_ack_pulse", 32'(acks), 32'd1);
        end_of_frame();
        @(negedge clk);
        check("restart_ack", 32'(ack), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        req = 1'b0;

        // Reset on the 9th write aborts the frame.
        run_pixels(9, -1, acks);
        rst = 1'b1;
        @(negedge clk);
        check("abort_de_req", 32'(de_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        start_frame(1'b0);
        run_pixels(32, -1, acks);
        end_of_frame();

        // Stepping: start -2.0, step 0.5; colours from hand-iterated orbits, row wrap at pixel 8.
        r1 = 16'hE000; r2 = 16'h0000; r3 = 16'h8000;
        fill_col(0);
        exp_col[0] = 1; exp_col[5] = 5; exp_col[6] = 2; exp_col[7] = 2;
        exp_col[8] = 1; exp_col[9] = 3;
        start_frame(1'b0);
        run_pixels(10, -1, acks);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Max iteration 0 is treated as 1: origin caps on the first iteration.
        r0 = 16'd0; r1 = 16'd0; r3 = 16'd0; exp_max = 1; fill_col(0);
        start_frame(1'b0);
        run_pixels(4, -1, acks);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

`ifdef JULIA_MODE_EN
        // Julia with c = 3.0, z0 = 0: escapes at iteration 2.
        r0 = 16'd16; exp_max = 16;
        r1 = 16'd0; r2 = 16'd0; r3 = 16'd0;
        r4 = 16'h3000; r5 = 16'd0; r6 = 16'd1;
        fill_col(2);
        start_frame(1'b0);
        run_pixels(32, -1, acks);
        end_of_frame();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
